// File: rtl/imsic_pkg.sv
// Shared constants and types for the IMSIC MSI write responder.
package imsic_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  RESP_DECERR      = 2'b11;
  localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
  localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;
  localparam int unsigned PAGE_SHIFT       = 12;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/imsic_msi_axil_slave_if.sv
// AXI-Lite write channel (AW/W/B) between the bus master and the MSI responder.
interface imsic_msi_axil_slave_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        b_valid;
  logic                        b_ready;
  logic [1:0]                  b_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/imsic_msi_decode.sv
// Combinational decode of one MSI write into target IMSIC, file and identity.
module imsic_msi_decode
  import imsic_pkg::*;
#(
  parameter int unsigned NR_SRC         = 30,
  parameter int unsigned NR_IMSICS      = 1,
  parameter int unsigned NR_INTP_FILES  = 2,
  parameter int unsigned INTP_FILE_LEN  = $clog2(NR_INTP_FILES),
  parameter int unsigned NR_SRC_LEN     = $clog2(NR_SRC),
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR      = 64'h2400_0000
) (
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_strb,
  output logic                        o_decerr,
  output logic                        o_hit,
  output logic [NR_IMSICS-1:0]        o_imsic_en,
  output logic [INTP_FILE_LEN-1:0]    o_file,
  output logic [NR_SRC_LEN-1:0]       o_id
);

  localparam logic [AXI_ADDR_WIDTH-1:0] Base = AXI_ADDR_WIDTH'(BASE_ADDR);

  logic [AXI_ADDR_WIDTH-1:0] w_off;
  logic [AXI_ADDR_WIDTH-1:0] w_page;
  logic [AXI_ADDR_WIDTH-1:0] w_imsic_idx;
  logic [INTP_FILE_LEN-1:0]  w_file;
  logic                      w_below;
  logic                      w_imsic_oor;
  logic                      w_file_oor;
  logic                      w_lane;
  logic [31:0]               w_word;
  logic [3:0]                w_lane_strb;
  logic                      w_is_le;
  logic                      w_is_be;
  logic [31:0]               w_id32;
  logic                      w_id_ok;

  assign w_off       = i_addr - Base;
  assign w_page      = w_off >> PAGE_SHIFT;
  assign w_file      = w_page[INTP_FILE_LEN-1:0];
  assign w_imsic_idx = w_page >> INTP_FILE_LEN;

  assign w_below     = i_addr < Base;
  assign w_imsic_oor = w_imsic_idx >= AXI_ADDR_WIDTH'(NR_IMSICS);
  assign w_file_oor  = 32'(w_file) >= NR_INTP_FILES;
  assign o_decerr    = w_below || w_imsic_oor || w_file_oor;

  // On a 64-bit bus the 32-bit register sits in the lane picked by addr[2].
  assign w_lane      = (AXI_DATA_WIDTH >= 64) ? i_addr[2] : 1'b0;
  assign w_word      = 32'(i_data >> {w_lane, 5'd0});
  assign w_lane_strb = 4'(i_strb >> {w_lane, 2'd0});

  assign w_is_le = (w_off[11:0] == SETEIPNUM_LE_OFF);
  assign w_is_be = (w_off[11:0] == SETEIPNUM_BE_OFF);
  assign w_id32  = w_is_be ? bswap32(w_word) : w_word;
  assign w_id_ok = (w_id32 != 32'd0) && (w_id32 <= 32'(NR_SRC - 1));

  assign o_hit  = !o_decerr && (w_is_le || w_is_be) && (&w_lane_strb) && w_id_ok;
  assign o_id   = w_id32[NR_SRC_LEN-1:0];
  assign o_file = w_file;

  always_comb begin
    o_imsic_en = '0;
    for (int unsigned i = 0; i < NR_IMSICS; i++) begin
      if (w_imsic_idx == AXI_ADDR_WIDTH'(i)) o_imsic_en[i] = 1'b1;
    end
  end

endmodule

// File: rtl/imsic_msi_axil_slave.sv
// AXI-Lite write responder: terminates MSI writes and pulses setipnum toward the interrupt files.
module imsic_msi_axil_slave
  import imsic_pkg::*;
#(
  parameter int unsigned NR_SRC                = 30,
  parameter int unsigned NR_IMSICS             = 1,
  parameter int unsigned NR_VS_FILES_PER_IMSIC = 0,
  parameter int unsigned NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
  parameter int unsigned INTP_FILE_LEN         = $clog2(NR_INTP_FILES),
  parameter int unsigned NR_SRC_LEN            = $clog2(NR_SRC),
  parameter int unsigned AXI_ADDR_WIDTH        = 64,
  parameter int unsigned AXI_DATA_WIDTH        = 64,
  parameter logic [63:0] BASE_ADDR             = 64'h2400_0000
) (
  input  logic                     i_clk,
  input  logic                     ni_rst,
  imsic_msi_axil_slave_if.slave    axi,
  output logic                     o_setipnum_valid,
  output logic [NR_SRC_LEN-1:0]    o_setipnum,
  output logic [NR_IMSICS-1:0]     o_imsic_en,
  output logic [INTP_FILE_LEN-1:0] o_select_file
);

  state_e                      r_state;
  state_e                      w_state_next;
  logic                        r_aw_full;
  logic                        r_w_full;
  logic [AXI_ADDR_WIDTH-1:0]   r_aw_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_w_data;
  logic [AXI_DATA_WIDTH/8-1:0] r_w_strb;
  logic [1:0]                  r_b_resp;
  logic                        r_pulse;
  logic [NR_SRC_LEN-1:0]       r_setipnum;
  logic [NR_IMSICS-1:0]        r_imsic_en;
  logic [INTP_FILE_LEN-1:0]    r_select_file;

  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_go;
  logic [AXI_ADDR_WIDTH-1:0]   w_addr;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_dec_decerr;
  logic                        w_dec_hit;
  logic [NR_IMSICS-1:0]        w_dec_imsic_en;
  logic [INTP_FILE_LEN-1:0]    w_dec_file;
  logic [NR_SRC_LEN-1:0]       w_dec_id;

  assign axi.aw_ready = (r_state == StIdle) && !r_aw_full;
  assign axi.w_ready  = (r_state == StIdle) && !r_w_full;
  assign axi.b_valid  = (r_state == StResp);
  assign axi.b_resp   = r_b_resp;

  assign w_aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_w_hs  = axi.w_valid && axi.w_ready;

  // Decode sees the channel being accepted this edge, or the held copy.
  assign w_addr = r_aw_full ? r_aw_addr : axi.aw_addr;
  assign w_data = r_w_full ? r_w_data : axi.w_data;
  assign w_strb = r_w_full ? r_w_strb : axi.w_strb;
  assign w_go   = (r_state == StIdle) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

  imsic_msi_decode #(
    .NR_SRC         (NR_SRC),
    .NR_IMSICS      (NR_IMSICS),
    .NR_INTP_FILES  (NR_INTP_FILES),
    .INTP_FILE_LEN  (INTP_FILE_LEN),
    .NR_SRC_LEN     (NR_SRC_LEN),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .BASE_ADDR      (BASE_ADDR)
  ) u_decode (
    .i_addr     (w_addr),
    .i_data     (w_data),
    .i_strb     (w_strb),
    .o_decerr   (w_dec_decerr),
    .o_hit      (w_dec_hit),
    .o_imsic_en (w_dec_imsic_en),
    .o_file     (w_dec_file),
    .o_id       (w_dec_id)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_go) w_state_next = StResp;
      StResp:  if (axi.b_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) r_aw_addr <= axi.aw_addr;
      if (w_w_hs) begin
        r_w_data <= axi.w_data;
        r_w_strb <= axi.w_strb;
      end
      if (w_go) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_full <= 1'b1;
        if (w_w_hs)  r_w_full  <= 1'b1;
      end
    end
  end

  // Sideband is only loaded on the IDLE->RESP edge, so the pulse lasts one cycle.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_b_resp      <= RESP_OKAY;
      r_pulse       <= 1'b0;
      r_setipnum    <= '0;
      r_imsic_en    <= '0;
      r_select_file <= '0;
    end else if (w_go) begin
      r_b_resp      <= w_dec_decerr ? RESP_DECERR : RESP_OKAY;
      r_pulse       <= w_dec_hit;
      r_setipnum    <= w_dec_hit ? w_dec_id : '0;
      r_imsic_en    <= w_dec_hit ? w_dec_imsic_en : '0;
      r_select_file <= w_dec_hit ? w_dec_file : '0;
    end else begin
      r_pulse       <= 1'b0;
      r_setipnum    <= '0;
      r_imsic_en    <= '0;
      r_select_file <= '0;
      if (axi.b_valid && axi.b_ready) r_b_resp <= RESP_OKAY;
    end
  end

  assign o_setipnum_valid = r_pulse;
  assign o_setipnum       = r_setipnum;
  assign o_imsic_en       = r_imsic_en;
  assign o_select_file    = r_select_file;

endmodule

// File: tb/tb_imsic_msi_axil_slave.sv
// Scoreboard bench for imsic_msi_axil_slave: directed MSI writes, monitor checks each B response.
module tb_imsic_msi_axil_slave;

  typedef struct packed {
    logic [1:0] resp;
    logic       pulse;
    logic [4:0] id;
    logic [1:0] en;
    logic       file;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       setipnum_valid;
  logic [4:0] setipnum;
  logic [1:0] imsic_en;
  logic       select_file;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  bit   seen = 1'b0;
  logic [1:0] held_resp = 2'b00;

  imsic_msi_axil_slave_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) axi ();

  imsic_msi_axil_slave #(
    .NR_SRC    (30),
    .NR_IMSICS (2),
    .BASE_ADDR (64'h2400_0000)
  ) dut (
    .i_clk            (clk),
    .ni_rst           (rst_n),
    .axi              (axi),
    .o_setipnum_valid (setipnum_valid),
    .o_setipnum       (setipnum),
    .o_imsic_en       (imsic_en),
    .o_select_file    (select_file)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on the first cycle of each response, then checks stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!axi.b_valid) begin
      seen = 1'b0;
      chk("idle_sideband", {setipnum_valid, setipnum, imsic_en, select_file}, '0);
    end else if (!seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bresp", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("b_resp", axi.b_resp, e.resp);
        chk("pulse", setipnum_valid, e.pulse);
        chk("setipnum", setipnum, e.id);
        chk("imsic_en", imsic_en, e.en);
        chk("select_file", select_file, e.file);
      end
      seen = 1'b1;
      held_resp = axi.b_resp;
    end else begin
      chk("stall_no_repulse", setipnum_valid, 1'b0);
      chk("stall_resp_stable", axi.b_resp, held_resp);
    end
    if (axi.b_valid && axi.b_ready) seen = 1'b0;
  end

  task automatic send_aw(input logic [63:0] a);
    bit done = 1'b0;
    int n = 0;
    axi.aw_valid = 1'b1;
    axi.aw_addr  = a;
    while (!done && n < 20) begin
      @(negedge clk);
      done = axi.aw_ready;
      n++;
    end
    if (!done) chk("aw_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1 axi.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit done = 1'b0;
    int n = 0;
    axi.w_valid = 1'b1;
    axi.w_data  = d;
    axi.w_strb  = s;
    while (!done && n < 20) begin
      @(negedge clk);
      done = axi.w_ready;
      n++;
    end
    if (!done) chk("w_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1 axi.w_valid = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                    input exp_t e);
    exp_q.push_back(e);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    axi.aw_valid = 1'b0;
    axi.aw_addr  = '0;
    axi.w_valid  = 1'b0;
    axi.w_data   = '0;
    axi.w_strb   = '0;
    axi.b_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_aw_ready", axi.aw_ready, 1'b1);
    chk("rst_w_ready", axi.w_ready, 1'b1);
    chk("rst_b_valid", axi.b_valid, 1'b0);
    chk("rst_b_resp", axi.b_resp, 2'b00);

    // Same-cycle AW/W, LE lane 0; response must appear the very next cycle.
    wr(64'h2400_0000, 64'd5, 8'h0F, '{2'b00, 1'b1, 5'd5, 2'b01, 1'b0});
    chk("latency_b_valid", axi.b_valid, 1'b1);
    chk("latency_pulse", setipnum_valid, 1'b1);
    chk("busy_aw_ready", axi.aw_ready, 1'b0);
    settle();

    // BE register, upper lane, IMSIC 1 file 1.
    wr(64'h2400_3004, 64'h0700_0000_0000_0000, 8'hF0, '{2'b00, 1'b1, 5'd7, 2'b10, 1'b1});
    settle();

    // W first, AW three cycles later, B stalled four cycles.
    axi.b_ready = 1'b0;
    exp_q.push_back('{2'b00, 1'b1, 5'd9, 2'b01, 1'b1});
    send_w(64'd9, 8'h0F);
    chk("w_ready_held_low", axi.w_ready, 1'b0);
    chk("aw_ready_still_high", axi.aw_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("w_ready_still_low", axi.w_ready, 1'b0);
    send_aw(64'h2400_1000);
    repeat (4) @(posedge clk);
    #1;
    chk("stalled_b_valid", axi.b_valid, 1'b1);
    axi.b_ready = 1'b1;
    settle();
    chk("ready_after_b", axi.aw_ready & axi.w_ready, 1'b1);

    // Out-of-range IDs, partial strobe, unknown offset: OKAY without a pulse.
    wr(64'h2400_0000, 64'd0,       8'h0F, '{2'b00, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h2400_0000, 64'd30,      8'h0F, '{2'b00, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h2400_0000, 64'h1_0005,  8'h0F, '{2'b00, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h2400_0000, 64'd5,       8'h07, '{2'b00, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h2400_0008, 64'd5,       8'hFF, '{2'b00, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h2400_0000, 64'd29,      8'h0F, '{2'b00, 1'b1, 5'd29, 2'b01, 1'b0});
    settle();

    // DECERR: IMSIC index 2, and below the window; then a good write.
    wr(64'h2400_4000, 64'd5, 8'h0F, '{2'b11, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h23FF_F000, 64'd5, 8'h0F, '{2'b11, 1'b0, 5'd0, 2'b00, 1'b0});
    settle();
    wr(64'h2400_2000, 64'd3, 8'h0F, '{2'b00, 1'b1, 5'd3, 2'b10, 1'b0});
    settle();

    // Reset while a response is stalled.
    axi.b_ready = 1'b0;
    wr(64'h2400_1000, 64'd4, 8'h0F, '{2'b00, 1'b1, 5'd4, 2'b01, 1'b1});
    @(posedge clk);
    #2;
    chk("pre_reset_b_valid", axi.b_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_b_valid", axi.b_valid, 1'b0);
    chk("async_reset_pulse", setipnum_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    axi.b_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_readies", {axi.aw_ready, axi.w_ready}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    wr(64'h2400_0004, 64'h0000_0000_0000_0000 | (64'h0B00_0000 << 32), 8'hF0,
       '{2'b00, 1'b1, 5'd11, 2'b01, 1'b0});
    settle();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
